// File: rtl/pot_adc_responder_if.sv
// Serial ADC link between an initiator (potentiometer reader) and the responder.
// CS/SCLK are driven by the master; the responder drives data plus its pad enable.
interface pot_adc_responder_if;
  // Handshake: cs_n_in low opens a frame. Each sclk_in fall advances one bit.
  // The master samples sdata_out while sclk_in is high. cs_n_in high closes the frame.
  logic cs_n_in;
  logic sclk_in;
  logic sdata_out;
  logic sdata_oe;

  modport master (
    output cs_n_in,
    output sclk_in,
    input  sdata_out,
    input  sdata_oe
  );

  modport slave (
    input  cs_n_in,
    input  sclk_in,
    output sdata_out,
    output sdata_oe
  );
endinterface

// File: rtl/pot_adc_responder.sv
// Converter side of a Pmod AD1-style serial link: on CS fall it snapshots sample_in
// and shifts out LEAD_ZEROS zeros followed by the sample, MSB first, one bit per SCLK fall.
module pot_adc_responder #(
  parameter int DATA_W      = 12,
  parameter int LEAD_ZEROS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              board_clk,
  input  logic              reset,
  pot_adc_responder_if.slave link,
  input  logic [DATA_W-1:0] sample_in,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort,
  output logic [7:0]        frame_count,
  output logic [1:0]        dbg_state
);

  localparam int FRAME_BITS = LEAD_ZEROS + DATA_W;
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Synchronizers reset to 1 (the idle level of both pins) so reset release makes no edge.
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic                   cs_d;
  logic                   sclk_d;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sclk_fall;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= '1;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], link.cs_n_in};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], link.sclk_in};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  state_t                  state, state_nxt;
  logic [FRAME_BITS-1:0]   shift_reg, shift_nxt;
  logic [4:0]              bit_cnt, bit_cnt_nxt;
  logic                    sdata_q, sdata_nxt;
  logic                    oe_q, oe_nxt;
  logic                    busy_nxt;
  logic                    done_nxt;
  logic                    abort_nxt;
  logic [7:0]              count_nxt;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      sdata_q     <= 1'b0;
      oe_q        <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      shift_reg   <= shift_nxt;
      bit_cnt     <= bit_cnt_nxt;
      sdata_q     <= sdata_nxt;
      oe_q        <= oe_nxt;
      busy        <= busy_nxt;
      frame_done  <= done_nxt;
      frame_abort <= abort_nxt;
      frame_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    bit_cnt_nxt = bit_cnt;
    sdata_nxt   = sdata_q;
    oe_nxt      = oe_q;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    abort_nxt   = 1'b0;
    count_nxt   = frame_count;

    unique case (state)
      IDLE: begin
        sdata_nxt = 1'b0;
        oe_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        if (cs_fall) begin
          shift_nxt   = FRAME_BITS'(sample_in);
          sdata_nxt   = shift_nxt[FRAME_BITS-1];
          oe_nxt      = 1'b1;
          busy_nxt    = 1'b1;
          bit_cnt_nxt = 5'd1;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // CS release outranks a coincident SCLK fall, even on the last bit.
        if (cs_rise) begin
          abort_nxt = 1'b1;
          sdata_nxt = 1'b0;
          oe_nxt    = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (sclk_fall) begin
          if (bit_cnt == LAST_BIT) begin
            sdata_nxt = 1'b0;
            done_nxt  = 1'b1;
            count_nxt = frame_count + 8'd1;
            state_nxt = DONE;
          end else begin
            shift_nxt   = {shift_reg[FRAME_BITS-2:0], 1'b0};
            sdata_nxt   = shift_nxt[FRAME_BITS-1];
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end
      end
      DONE: begin
        sdata_nxt = 1'b0;
        if (cs_rise) begin
          oe_nxt    = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign link.sdata_out = sdata_q;
  assign link.sdata_oe  = oe_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_pot_adc_responder.sv
// Bench for pot_adc_responder: an initiator drives CS/SCLK frames and queues the expected
// capture; a monitor records sdata_out before every SCLK fall and checks each frame on CS rise.
module tb_pot_adc_responder;

  typedef struct packed {
    logic [7:0]  cnt;
    logic [1:0]  dones;
    logic [1:0]  aborts;
    logic        rst_mid;
    logic [4:0]  nbits;
    logic [19:0] bits;
  } exp_t;

  logic        board_clk;
  logic        reset;
  logic [11:0] sample_in;
  logic        busy;
  logic        frame_done;
  logic        frame_abort;
  logic [7:0]  frame_count;
  logic [1:0]  dbg_state;

  pot_adc_responder_if link ();

  pot_adc_responder dut (
    .board_clk   (board_clk),
    .reset       (reset),
    .link        (link.slave),
    .sample_in   (sample_in),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .frame_count (frame_count),
    .dbg_state   (dbg_state)
  );

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_fail = 0;
  int         done_seen = 0;
  int         abort_seen = 0;
  logic [7:0] exp_count = 8'd0;

  // Clock and reset
  initial begin
    board_clk = 1'b0;
    forever #5 board_clk = ~board_clk;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  always @(negedge board_clk) begin
    if (frame_done)  done_seen  <= done_seen + 1;
    if (frame_abort) abort_seen <= abort_seen + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge board_clk);
  endtask

  task automatic sclk_pulses(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      link.sclk_in = 1'b0;
      wait_clk(half);
      link.sclk_in = 1'b1;
      wait_clk(half);
    end
  endtask

  task automatic run_frame(input logic [11:0] smp, input logic [11:0] smp_late,
                           input int pulses, input int half, input logic [19:0] bits,
                           input int dones, input int aborts);
    exp_t e;
    if (dones != 0) exp_count = exp_count + 8'd1;
    e.cnt     = exp_count;
    e.dones   = 2'(dones);
    e.aborts  = 2'(aborts);
    e.rst_mid = 1'b0;
    e.nbits   = 5'(pulses);
    e.bits    = bits;
    exp_q.push_back(e);
    sample_in = smp;
    wait_clk(1);
    link.cs_n_in = 1'b0;
    wait_clk(4);
    sample_in = smp_late;
    wait_clk(half - 4);
    sclk_pulses(pulses, half);
    link.cs_n_in = 1'b1;
    wait_clk(half + 6);
  endtask

  // Monitor / scoreboard: data is stable from each SCLK rise until 3 cycles after the
  // next fall, so the value present at a fall is the bit the initiator captured.
  initial begin : monitor
    exp_t        e;
    logic [19:0] cap;
    int          nb;
    int          d0;
    int          a0;
    forever begin
      @(negedge link.cs_n_in);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_frame: got a frame, expected none queued");
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
      cap = '0;
      nb  = 0;
      d0  = done_seen;
      a0  = abort_seen;
      repeat (2) @(posedge board_clk);
      #1 check("busy_before_sync", {31'd0, busy}, 32'd0);
      @(posedge board_clk);
      #1;
      check("busy_start", {31'd0, busy}, 32'd1);
      check("oe_start", {31'd0, link.sdata_oe}, 32'd1);
      while (link.cs_n_in == 1'b0) begin
        @(negedge link.sclk_in or posedge link.cs_n_in);
        if (link.cs_n_in == 1'b0) begin
          cap = {cap[18:0], link.sdata_out};
          nb++;
        end
      end
      repeat (2) @(posedge board_clk);
      #1 if (!e.rst_mid) check("oe_hold_after_cs", {31'd0, link.sdata_oe}, 32'd1);
      @(posedge board_clk);
      #1;
      check("oe_end", {31'd0, link.sdata_oe}, 32'd0);
      check("busy_end", {31'd0, busy}, 32'd0);
      @(negedge board_clk);
      #1;
      check("captured_bits", {12'd0, cap}, {12'd0, e.bits});
      check("bit_count", nb, {27'd0, e.nbits});
      check("done_pulses", done_seen - d0, {30'd0, e.dones});
      check("abort_pulses", abort_seen - a0, {30'd0, e.aborts});
      check("frame_count", {24'd0, frame_count}, {24'd0, e.cnt});
    end
  end

  // Stimulus
  initial begin : stimulus
    exp_t        e;
    logic [11:0] smp;
    int          d0;
    logic [7:0]  c0;
    reset        = 1'b1;
    link.cs_n_in = 1'b1;
    link.sclk_in = 1'b1;
    sample_in    = '0;
    wait_clk(3);
    check("rst_sdata", {31'd0, link.sdata_out}, 32'd0);
    check("rst_oe", {31'd0, link.sdata_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_abort", {31'd0, frame_abort}, 32'd0);
    check("rst_count", {24'd0, frame_count}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    wait_clk(5);

    run_frame(12'hA5C, 12'hA5C, 16, 25, 20'h00A5C, 1, 0);
    run_frame(12'hFFF, 12'h000, 16, 25, 20'h00FFF, 1, 0);
    run_frame(12'h123, 12'h123, 7, 25, 20'h00000, 0, 1);
    run_frame(12'h123, 12'h123, 16, 25, 20'h00123, 1, 0);
    run_frame(12'h800, 12'h800, 20, 25, 20'h08000, 1, 0);

    // SCLK activity with CS high must leave the outputs idle.
    d0 = done_seen;
    c0 = frame_count;
    for (int i = 0; i < 4; i++) begin
      link.sclk_in = 1'b0;
      wait_clk(5);
      check("idle_sclk_sdata", {31'd0, link.sdata_out}, 32'd0);
      check("idle_sclk_oe", {31'd0, link.sdata_oe}, 32'd0);
      link.sclk_in = 1'b1;
      wait_clk(5);
      check("idle_sclk_busy", {31'd0, busy}, 32'd0);
    end
    check("idle_sclk_done", done_seen - d0, 32'd0);
    check("idle_sclk_count", {24'd0, frame_count}, {24'd0, c0});

    // Reset in the middle of a frame after 9 SCLK falls.
    exp_count = 8'd0;
    e.cnt     = 8'd0;
    e.dones   = 2'd0;
    e.aborts  = 2'd0;
    e.rst_mid = 1'b1;
    e.nbits   = 5'd9;
    e.bits    = 20'h00007;
    exp_q.push_back(e);
    sample_in = 12'h3C3;
    wait_clk(1);
    link.cs_n_in = 1'b0;
    wait_clk(25);
    sclk_pulses(9, 25);
    reset = 1'b1;
    #1;
    check("midrst_sdata", {31'd0, link.sdata_out}, 32'd0);
    check("midrst_oe", {31'd0, link.sdata_oe}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_abort", {31'd0, frame_abort}, 32'd0);
    check("midrst_count", {24'd0, frame_count}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, 32'd0);
    wait_clk(3);
    link.cs_n_in = 1'b1;
    wait_clk(10);
    reset = 1'b0;
    wait_clk(6);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    run_frame(12'h3C3, 12'h3C3, 16, 25, 20'h003C3, 1, 0);

    // 255 more frames: 256 completed since reset, so frame_count wraps to 0.
    for (int i = 0; i < 255; i++) begin
      smp = 12'(i * 17 + 5);
      run_frame(smp, smp, 16, 5, {8'h00, smp}, 1, 0);
    end
    wait_clk(20);
    check("wrap_count", {24'd0, frame_count}, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
